chaos_key_scheduler: RTL and testbench

- Upstream of the 32-bit chaos logic unit; drives its 12-bit gate-configuration key (6 bits per 16-bit half).
- Holds a small bank of software-loaded keys and rotates the active key periodically or on request.
- Swaps keys only when the downstream logic op is idle, so no operation ever sees a mid-flight key change.
- Optional LFSR whitening XORs the selected slot with a 12-bit LFSR for extra obfuscation.

---
 rtl/chaos_key_scheduler_pkg.sv | 19 +
 rtl/chaos_key_lfsr.sv | 22 ++
 rtl/chaos_key_scheduler.sv | 145 ++++++++++++++
 tb/tb_chaos_key_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/chaos_key_scheduler_pkg.sv
// Shared constants and FSM state encoding for the chaos key scheduler.
package chaos_pkg;

   localparam int KEY_W = 12;
   localparam int LFSR_W = 12;

   // x^12 + x^6 + x^4 + x + 1, right-shifting Galois tap mask
   localparam logic [LFSR_W-1:0] LFSR_POLY = 12'h829;
   localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 12'hACE;

   typedef enum logic [2:0] {
      EMPTY = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      PEND  = 3'd3,
      SWAP  = 3'd4
   } ks_state_t;

endpackage

// File: rtl/chaos_key_lfsr.sv
// 12-bit Galois LFSR used to whiten rotated keys; steps only when adv is high.
module chaos_key_lfsr
   import chaos_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              adv,
   output logic [LFSR_W-1:0] state
);

   // shift right, fold taps in when the bit shifted out is 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEED;
      end else if (adv) begin
         state <= (state >> 1) ^ (state[0] ? LFSR_POLY : '0);
      end
   end

endmodule

// File: rtl/chaos_key_scheduler.sv
// Key bank plus rotation sequencer feeding the chaos logic unit's gate key.
//
// state | meaning
// EMPTY | no slot loaded yet, waiting for a valid slot
// LOAD  | one cycle, latch lowest valid slot into key
// RUN   | counting down to the next rotation
// PEND  | rotation due, holding key until alu_busy drops
// SWAP  | one cycle, latch next valid slot (optionally whitened)
module chaos_key_scheduler #(
   parameter int          NUM_SLOTS = 4,
   parameter int          KEY_W     = 12,
   parameter int          PERIOD_W  = 16,
   parameter logic [11:0] LFSR_SEED = 12'hACE
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cfg_we,
   input  logic [$clog2(NUM_SLOTS)-1:0] cfg_addr,
   input  logic [KEY_W-1:0]             cfg_wdata,
   input  logic [PERIOD_W-1:0]          period,
   input  logic                         rot_req,
   input  logic                         whiten_en,
   input  logic                         alu_busy,
   output logic [KEY_W-1:0]             key,
   output logic                         key_valid,
   output logic [$clog2(NUM_SLOTS)-1:0] key_idx,
   output logic                         rot_pulse
);
   import chaos_pkg::*;

   localparam int IDX_W = $clog2(NUM_SLOTS);

   logic [KEY_W-1:0]    bank [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] slot_vld;
   ks_state_t            state;
   logic [PERIOD_W-1:0]  cnt;
   logic                 run_first;
   logic [LFSR_W-1:0]    lfsr_q;
   logic [IDX_W-1:0]     low_idx;
   logic [IDX_W-1:0]     next_idx;
   logic [IDX_W-1:0]     cand;
   logic                 found;
   logic                 rot_due;
   logic [KEY_W-1:0]     whiten_mask;

   chaos_key_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (state == SWAP),
      .state (lfsr_q)
   );

   // key bank storage; contents survive reset, only valid bits are cleared
   always_ff @(posedge clk) begin
      if (cfg_we) begin
         bank[cfg_addr] <= cfg_wdata;
      end
   end

   // per-slot valid bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_vld <= '0;
      end else if (cfg_we) begin
         slot_vld[cfg_addr] <= 1'b1;
      end
   end

   // lowest valid slot for initial load
   always_comb begin
      low_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (slot_vld[i]) low_idx = IDX_W'(i);
      end
   end

   // next valid slot after key_idx; offset NUM_SLOTS wraps back onto key_idx itself
   always_comb begin
      next_idx = key_idx;
      found    = 1'b0;
      cand     = '0;
      for (int i = 1; i <= NUM_SLOTS; i++) begin
         cand = key_idx + IDX_W'(i);
         if (!found && slot_vld[cand]) begin
            next_idx = cand;
            found    = 1'b1;
         end
      end
   end

   // the counter is reloaded during the first RUN cycle, so it is ignored there
   always_comb begin
      rot_due     = rot_req || (!run_first && (period != '0) && (cnt == PERIOD_W'(1)));
      whiten_mask = whiten_en ? KEY_W'(lfsr_q) : '0;
   end

   // rotation sequencer with registered key outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         key       <= '0;
         key_valid <= 1'b0;
         key_idx   <= '0;
         rot_pulse <= 1'b0;
         cnt       <= '0;
         run_first <= 1'b0;
      end else begin
         rot_pulse <= 1'b0;
         case (state)
            EMPTY: begin
               if (|slot_vld) state <= LOAD;
            end
            LOAD: begin
               key       <= bank[low_idx];
               key_idx   <= low_idx;
               key_valid <= 1'b1;
               rot_pulse <= 1'b1;
               run_first <= 1'b1;
               state     <= RUN;
            end
            RUN: begin
               run_first <= 1'b0;
               if (run_first) begin
                  cnt <= period;
               end else if (cnt != '0) begin
                  cnt <= cnt - PERIOD_W'(1);
               end
               if (rot_due) state <= alu_busy ? PEND : SWAP;
            end
            PEND: begin
               if (!alu_busy) state <= SWAP;
            end
            SWAP: begin
               key       <= bank[next_idx] ^ whiten_mask;
               key_idx   <= next_idx;
               rot_pulse <= 1'b1;
               run_first <= 1'b1;
               state     <= RUN;
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_chaos_key_scheduler.sv
// Directed bench for chaos_key_scheduler: load, auto/manual rotation,
// slot skipping, busy hold-off, whitening and async reset.
module tb_chaos_key_scheduler;

   logic        clk;
   logic        rst_n;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [11:0] cfg_wdata;
   logic [15:0] period;
   logic        rot_req;
   logic        whiten_en;
   logic        alu_busy;
   logic [11:0] key;
   logic        key_valid;
   logic [1:0]  key_idx;
   logic        rot_pulse;

   int vectors = 0;
   int miscompares = 0;
   int n;
   int pulses;
   int keychg;

   chaos_key_scheduler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .period    (period),
      .rot_req   (rot_req),
      .whiten_en (whiten_en),
      .alu_busy  (alu_busy),
      .key       (key),
      .key_valid (key_valid),
      .key_idx   (key_idx),
      .rot_pulse (rot_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // called at a negedge; one posedge captures the write
   task automatic wr(input logic [1:0] a, input logic [11:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      @(negedge clk);
      cfg_we    = 1'b0;
   endtask

   // one-cycle rot_req, returns at the negedge after the swap edge
   task automatic rot();
      rot_req = 1'b1;
      @(negedge clk);
      rot_req = 1'b0;
      @(negedge clk);
   endtask

   // negedges until rot_pulse is seen; limit+1 on timeout
   task automatic wait_pulse(input int limit, output int cnt_o);
      cnt_o = limit + 1;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (rot_pulse) begin
            cnt_o = i;
            break;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      period = '0; rot_req = 1'b0; whiten_en = 1'b0; alu_busy = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_key", key, 12'h000);
      chk("rst_valid", key_valid, 1'b0);
      chk("rst_idx", key_idx, 2'd0);
      chk("rst_pulse", rot_pulse, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // single slot, no auto rotation
      wr(2'd0, 12'h5A3);
      wait_pulse(10, n);
      chk("load_latency", n, 2);
      chk("load_key", key, 12'h5A3);
      chk("load_idx", key_idx, 2'd0);
      chk("load_valid", key_valid, 1'b1);
      pulses = 0; keychg = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rot_pulse) pulses++;
         if (key !== 12'h5A3) keychg++;
      end
      chk("idle_pulses", pulses, 0);
      chk("idle_keychg", keychg, 0);

      // fill bank; rewriting the active slot must not disturb key
      wr(2'd0, 12'h111);
      wr(2'd1, 12'h222);
      wr(2'd2, 12'h333);
      wr(2'd3, 12'h444);
      chk("active_write_hold", key, 12'h5A3);
      period  = 16'd10;
      rot_req = 1'b1;
      @(negedge clk);
      rot_req = 1'b0;
      chk("rotreq_edge1_pulse", rot_pulse, 1'b0);
      chk("rotreq_edge1_key", key, 12'h5A3);
      @(negedge clk);
      chk("rotreq_edge2_pulse", rot_pulse, 1'b1);
      chk("rotreq_key", key, 12'h222);
      chk("rotreq_idx", key_idx, 2'd1);
      wait_pulse(30, n); chk("auto_gap1", n, 12); chk("auto_key1", key, 12'h333);
      wait_pulse(30, n); chk("auto_gap2", n, 12); chk("auto_key2", key, 12'h444);
      wait_pulse(30, n); chk("auto_gap3", n, 12); chk("auto_key3", key, 12'h111);
      chk("auto_idx3", key_idx, 2'd0);
      wait_pulse(30, n); chk("auto_gap4", n, 12); chk("auto_key4", key, 12'h222);

      // reset mid-run clears outputs asynchronously
      period = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_key", key, 12'h000);
      chk("async_rst_valid", key_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // slot 1 never written: rotation skips it
      wr(2'd0, 12'h0A0);
      wr(2'd2, 12'h0B2);
      wr(2'd3, 12'h0C3);
      chk("skip_load_key", key, 12'h0A0);
      chk("skip_load_idx", key_idx, 2'd0);
      rot(); chk("skip_idx_a", key_idx, 2'd2); chk("skip_key_a", key, 12'h0B2);
      rot(); chk("skip_idx_b", key_idx, 2'd3); chk("skip_key_b", key, 12'h0C3);
      rot(); chk("skip_idx_c", key_idx, 2'd0); chk("skip_key_c", key, 12'h0A0);

      // busy hold-off: three requests absorbed into one swap
      alu_busy = 1'b1;
      pulses = 0; keychg = 0;
      for (int i = 0; i < 20; i++) begin
         rot_req = (i == 2 || i == 8 || i == 14);
         @(negedge clk);
         if (rot_pulse) pulses++;
         if (key !== 12'h0A0) keychg++;
      end
      rot_req = 1'b0;
      chk("busy_pulses", pulses, 0);
      chk("busy_keychg", keychg, 0);
      alu_busy = 1'b0;
      @(negedge clk);
      chk("unbusy_edge1_pulse", rot_pulse, 1'b0);
      chk("unbusy_edge1_key", key, 12'h0A0);
      @(negedge clk);
      chk("unbusy_edge2_pulse", rot_pulse, 1'b1);
      chk("unbusy_key", key, 12'h0B2);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rot_pulse) pulses++;
      end
      chk("unbusy_single_swap", pulses, 0);

      // whitening with an all-zero slot exposes the LFSR sequence
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      whiten_en = 1'b1;
      wr(2'd0, 12'h000);
      wait_pulse(10, n);
      chk("whiten_load_latency", n, 2);
      rot(); chk("whiten_k1", key, 12'hACE);
      rot(); chk("whiten_k2", key, 12'h567);
      rot(); chk("whiten_k3", key, 12'hA9A);
      rot(); chk("whiten_k4", key, 12'h54D);
      rot(); chk("whiten_k5", key, 12'hA8F);
      chk("whiten_idx", key_idx, 2'd0);

      // reset while parked in PEND, then reload picks lowest valid slot
      alu_busy = 1'b1;
      rot_req  = 1'b1;
      @(negedge clk);
      rot_req  = 1'b0;
      @(negedge clk);
      chk("pend_key_hold", key, 12'hA8F);
      #2 rst_n = 1'b0;
      #1;
      chk("pend_rst_key", key, 12'h000);
      chk("pend_rst_valid", key_valid, 1'b0);
      chk("pend_rst_idx", key_idx, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      alu_busy = 1'b0;
      whiten_en = 1'b0;
      wr(2'd3, 12'h7E7);
      wr(2'd1, 12'h1B1);
      wait_pulse(5, n);
      chk("reload_latency", n, 1);
      chk("reload_key", key, 12'h1B1);
      chk("reload_idx", key_idx, 2'd1);
      chk("reload_valid", key_valid, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
